// File: rtl/vga_bounce_box_module_if.sv
// ============================================================================
// Module  : vga_bounce_box_module_if
// Purpose : Video bundle between the sync generator and the pixel stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_bounce_box_module_if;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [10:0] Row_Addr_Sig;
  logic        HSYNC_Sig;
  logic        VSYNC_Sig;
  logic        HSYNC_Out;
  logic        VSYNC_Out;
  logic [4:0]  Red_Sig;
  logic [5:0]  Green_Sig;
  logic [4:0]  Blue_Sig;

  modport master (
    output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_Sig, VSYNC_Sig,
    input  HSYNC_Out, VSYNC_Out, Red_Sig, Green_Sig, Blue_Sig
  );

  modport slave (
    input  Ready_Sig, Column_Addr_Sig, Row_Addr_Sig, HSYNC_Sig, VSYNC_Sig,
    output HSYNC_Out, VSYNC_Out, Red_Sig, Green_Sig, Blue_Sig
  );
endinterface

`default_nettype wire

// File: rtl/vga_bounce_box_module.sv
// ============================================================================
// Module  : vga_bounce_box_module
// Purpose : Eight colour bars with a bouncing, colour-cycling square on top.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_bounce_box_module #(
  parameter int H_ACT = 1440,
  parameter int V_ACT = 900,
  parameter int BOX   = 64,
  parameter int STEP  = 4,
  parameter int BAR_W = 180
) (
  input  logic                    vga_clk,
  input  logic                    rst_n,
  input  logic                    Move_En,
  vga_bounce_box_module_if.slave  vid
);

  localparam logic [11:0] C_H_ACT    = 12'(H_ACT);
  localparam logic [11:0] C_V_ACT    = 12'(V_ACT);
  localparam logic [11:0] C_BOX      = 12'(BOX);
  localparam logic [11:0] C_STEP     = 12'(STEP);
  localparam logic [7:0]  C_BAR_LAST = 8'(BAR_W - 1);

  logic        vs_q;
  logic        hs_out_q, vs_out_q;
  logic [15:0] rgb_q, rgb_d;
  logic [7:0]  bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [10:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]  col_idx_q, col_idx_d;

  logic        tick;
  logic [12:0] nx, ny;
  logic [11:0] col_e, row_e, bx_e, by_e;
  logic        in_box;

  function automatic logic [15:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 16'hFFFF;
      3'd1:    palette = 16'hFFE0;
      3'd2:    palette = 16'h07FF;
      3'd3:    palette = 16'h07E0;
      3'd4:    palette = 16'hF81F;
      3'd5:    palette = 16'hF800;
      3'd6:    palette = 16'h001F;
      default: palette = 16'h0000;
    endcase
  endfunction

  // Result packing: [12] bounced, [11] new direction, [10:0] new position.
  function automatic logic [12:0] axis_next(input logic [10:0] pos, input logic dir,
                                            input logic [11:0] act);
    logic [11:0] p;
    p = {1'b0, pos};
    if (!dir) begin
      if (p + C_BOX + C_STEP >= act) axis_next = {1'b1, 1'b1, 11'(act - C_BOX)};
      else                           axis_next = {1'b0, 1'b0, 11'(p + C_STEP)};
    end else begin
      if (p <= C_STEP) axis_next = {1'b1, 1'b0, 11'd0};
      else             axis_next = {1'b0, 1'b1, 11'(p - C_STEP)};
    end
  endfunction

  assign tick = vs_q & ~vid.VSYNC_Sig;
  assign nx   = axis_next(box_x_q, dir_x_q, C_H_ACT);
  assign ny   = axis_next(box_y_q, dir_y_q, C_V_ACT);

  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (!vid.Ready_Sig) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (bar_cnt_q == C_BAR_LAST) begin
      bar_cnt_d = '0;
      if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_cnt_d = bar_cnt_q + 8'd1;
    end
  end

  // A corner hit bounces both axes but still advances the colour only once.
  always_comb begin
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    col_idx_d = col_idx_q;
    if (tick && Move_En) begin
      box_x_d   = nx[10:0];
      dir_x_d   = nx[11];
      box_y_d   = ny[10:0];
      dir_y_d   = ny[11];
      col_idx_d = col_idx_q + {2'b00, (nx[12] | ny[12])};
    end
  end

  assign col_e  = {1'b0, vid.Column_Addr_Sig};
  assign row_e  = {1'b0, vid.Row_Addr_Sig};
  assign bx_e   = {1'b0, box_x_q};
  assign by_e   = {1'b0, box_y_q};
  assign in_box = vid.Ready_Sig & (col_e >= bx_e) & (col_e < bx_e + C_BOX)
                                & (row_e >= by_e) & (row_e < by_e + C_BOX);

  always_comb begin
    rgb_d = '0;
    if (vid.Ready_Sig) rgb_d = in_box ? ~palette(col_idx_q) : palette(bar_idx_q);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      rgb_q     <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      box_x_q   <= '0;
      box_y_q   <= '0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      col_idx_q <= '0;
    end else begin
      vs_q      <= vid.VSYNC_Sig;
      hs_out_q  <= vid.HSYNC_Sig;
      vs_out_q  <= vid.VSYNC_Sig;
      rgb_q     <= rgb_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      col_idx_q <= col_idx_d;
    end
  end

  assign vid.HSYNC_Out = hs_out_q;
  assign vid.VSYNC_Out = vs_out_q;
  assign vid.Red_Sig   = rgb_q[15:11];
  assign vid.Green_Sig = rgb_q[10:5];
  assign vid.Blue_Sig  = rgb_q[4:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_bounce_box_module.sv
// ============================================================================
// Module  : tb_vga_bounce_box_module
// Purpose : Randomised scoreboard bench for the default and a 128x128 build.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_bounce_box_module;

  localparam int BOXV  = 64;
  localparam int STEPV = 4;
  localparam logic [15:0] PAL [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct packed {
    logic [17:0] a;
    logic [17:0] b;
  } exp_t;

  logic vga_clk;
  logic rst_n;
  logic move_en;

  vga_bounce_box_module_if if0 ();
  vga_bounce_box_module_if if1 ();

  vga_bounce_box_module u_dut0 (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .Move_En (move_en),
    .vid     (if0)
  );

  vga_bounce_box_module #(
    .H_ACT (128),
    .V_ACT (128),
    .BOX   (64),
    .STEP  (4),
    .BAR_W (16)
  ) u_dut1 (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .Move_En (move_en),
    .vid     (if1)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  // Reference model state, one entry per DUT.
  int   HA[2] = '{1440, 128};
  int   VA[2] = '{900, 128};
  int   BW[2] = '{180, 16};
  int   mx[2], my[2], mci[2];
  bit   mdx[2], mdy[2];
  bit   vs_d;
  int   run;

  task automatic check(string name, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void reset_model();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 0; my[k] = 0; mci[k] = 0; mdx[k] = 0; mdy[k] = 0;
    end
    vs_d = 0;
    run  = 0;
  endfunction

  function automatic void axis(input int p, input bit d, input int act,
                               output int np, output bit nd, output bit b);
    np = p; nd = d; b = 0;
    if (!d) begin
      if (p + BOXV + STEPV >= act) begin np = act - BOXV; nd = 1; b = 1; end
      else np = p + STEPV;
    end else begin
      if (p <= STEPV) begin np = 0; nd = 0; b = 1; end
      else np = p - STEPV;
    end
  endfunction

  function automatic void update(int k);
    int nx, ny;
    bit ndx, ndy, bx, by;
    axis(mx[k], mdx[k], HA[k], nx, ndx, bx);
    axis(my[k], mdy[k], VA[k], ny, ndy, by);
    mx[k] = nx; mdx[k] = ndx;
    my[k] = ny; mdy[k] = ndy;
    if (bx || by) mci[k] = (mci[k] + 1) % 8;
  endfunction

  // run = number of consecutive active pixels before this one on the line.
  function automatic logic [15:0] exp_rgb(int k, bit rdy, int col, int row);
    int b;
    if (!rdy) return 16'h0000;
    if (col >= mx[k] && col < mx[k] + BOXV && row >= my[k] && row < my[k] + BOXV)
      return ~PAL[mci[k]];
    b = run / BW[k];
    return PAL[(b > 7) ? 7 : b];
  endfunction

  task automatic apply(bit rdy, int col, int row, bit hs, bit vs);
    logic [10:0] c, r;
    exp_t e;
    c = col[10:0];
    r = row[10:0];
    if0.Ready_Sig = rdy; if0.Column_Addr_Sig = c; if0.Row_Addr_Sig = r;
    if0.HSYNC_Sig = hs;  if0.VSYNC_Sig = vs;
    if1.Ready_Sig = rdy; if1.Column_Addr_Sig = c; if1.Row_Addr_Sig = r;
    if1.HSYNC_Sig = hs;  if1.VSYNC_Sig = vs;
    e.a = {hs, vs, exp_rgb(0, rdy, int'(c), int'(r))};
    e.b = {hs, vs, exp_rgb(1, rdy, int'(c), int'(r))};
    q.push_back(e);
    if (vs_d && !vs && move_en) begin
      update(0);
      update(1);
    end
    vs_d = vs;
    run  = rdy ? run + 1 : 0;
  endtask

  task automatic step(bit rdy, int col, int row, bit hs, bit vs);
    @(negedge vga_clk);
    apply(rdy, col, row, hs, vs);
  endtask

  // Probe the corners and just-outside edges of each square, then a VSYNC fall.
  task automatic frame();
    int px[6], py[6];
    for (int k = 0; k < 2; k++) begin
      px = '{mx[k], mx[k] + 63, mx[k] - 1, mx[k] + 64, mx[k],      mx[k] + 63};
      py = '{my[k], my[k] + 63, my[k],     my[k] + 63, my[k] + 64, my[k] - 1};
      for (int i = 0; i < 6; i++) step(1, px[i], py[i], 1, 1);
      step(0, 0, 0, 1, 1);
    end
    repeat (4) step(bit'($urandom_range(0, 1)), $urandom_range(0, 1500),
                    $urandom_range(0, 950), bit'($urandom_range(0, 1)), 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("dut0_out", {if0.HSYNC_Out, if0.VSYNC_Out, if0.Red_Sig, if0.Green_Sig, if0.Blue_Sig}, e.a);
        check("dut1_out", {if1.HSYNC_Out, if1.VSYNC_Out, if1.Red_Sig, if1.Green_Sig, if1.Blue_Sig}, e.b);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    move_en = 1'b0;
    if0.Ready_Sig = 1'b1; if0.Column_Addr_Sig = '0; if0.Row_Addr_Sig = '0;
    if0.HSYNC_Sig = 1'b1; if0.VSYNC_Sig = 1'b1;
    if1.Ready_Sig = 1'b1; if1.Column_Addr_Sig = '0; if1.Row_Addr_Sig = '0;
    if1.HSYNC_Sig = 1'b1; if1.VSYNC_Sig = 1'b1;
    repeat (3) @(negedge vga_clk);
    check("reset0", {if0.HSYNC_Out, if0.VSYNC_Out, if0.Red_Sig, if0.Green_Sig, if0.Blue_Sig}, 18'd0);
    check("reset1", {if1.HSYNC_Out, if1.VSYNC_Out, if1.Red_Sig, if1.Green_Sig, if1.Blue_Sig}, 18'd0);
    rst_n = 1'b1;
    reset_model();
    apply(0, 0, 0, 1, 1);

    // Full active line below the square: all eight bars in order.
    for (int c = 0; c < 1440; c++) step(1, c, 100, 1, 1);
    step(0, 0, 0, 1, 1);

    // Square corners at reset position and the first pixel right of it.
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 63, 63, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 64, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Blanking with arbitrary address and sync activity, square frozen.
    repeat (40) step(0, $urandom_range(0, 2047), $urandom_range(0, 2047),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    step(0, 0, 0, 1, 1);

    move_en = 1'b1;
    repeat (344) frame();
    move_en = 1'b0;
    repeat (10) frame();
    repeat (40) begin
      move_en = bit'($urandom_range(0, 1));
      frame();
    end

    // Asynchronous reset in the middle of a frame.
    step(1, 700, 850, 1, 1);
    @(negedge vga_clk);
    rst_n = 1'b0;
    #1;
    check("midreset0", {if0.HSYNC_Out, if0.VSYNC_Out, if0.Red_Sig, if0.Green_Sig, if0.Blue_Sig}, 18'd0);
    check("midreset1", {if1.HSYNC_Out, if1.VSYNC_Out, if1.Red_Sig, if1.Green_Sig, if1.Blue_Sig}, 18'd0);
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
    reset_model();
    apply(0, 0, 0, 1, 1);
    move_en = 1'b1;
    repeat (20) frame();

    repeat (2) @(negedge vga_clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
